// File: rtl/rtm_pkg.sv
// Shared opcode and FSM state encodings for the register-transfer
// micro-controller.
package rtm_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOADI = 3'd1,
    OP_MOV   = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_AND   = 3'd5,
    OP_OR    = 3'd6,
    OP_XOR   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/rtm_alu.sv
// Combinational datapath: result, carry/borrow and zero flag for
// one command.
module rtm_alu
  import rtm_pkg::*;
#(
  parameter int n = 16
) (
  input  op_e          op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [n-1:0] imm,
  output logic [n-1:0] res,
  output logic         carry,
  output logic         zero
);

  logic [n:0] sum;
  logic [n:0] diff;

  // Bit n of the widened difference is the unsigned borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    unique case (op)
      OP_NOP:   res = '0;
      OP_LOADI: res = imm;
      OP_MOV:   res = a;
      OP_ADD: begin
        res   = sum[n-1:0];
        carry = sum[n];
      end
      OP_SUB: begin
        res   = diff[n-1:0];
        carry = diff[n];
      end
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/rtm_ctrl.sv
// Four-state register-transfer controller: accept, read, execute,
// write back, with a fixed latency for every opcode.
module rtm_ctrl
  import rtm_pkg::*;
#(
  parameter int n = 16,
  parameter int k = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [k-1:0] cmd_d,
  input  logic [k-1:0] cmd_sa,
  input  logic [k-1:0] cmd_sb,
  input  logic [n-1:0] cmd_imm,
  output logic [n-1:0] rf_x,
  output logic         rf_ld,
  output logic [k-1:0] rf_d,
  output logic [k-1:0] rf_sa,
  output logic [k-1:0] rf_sb,
  input  logic [n-1:0] rf_a,
  input  logic [n-1:0] rf_b,
  output logic         res_valid,
  output logic [n-1:0] res_data,
  output logic         res_zero,
  output logic         res_carry
);

  state_e       state_q;
  state_e       state_d;
  logic         rdy_q;
  op_e          op_q;
  logic [k-1:0] d_q;
  logic [k-1:0] sa_q;
  logic [k-1:0] sb_q;
  logic [n-1:0] imm_q;
  logic [n-1:0] a_q;
  logic [n-1:0] b_q;
  logic [n-1:0] res_q;
  logic         zero_q;
  logic         carry_q;
  logic [n-1:0] alu_res;
  logic         alu_carry;
  logic         alu_zero;
  logic         accept;

  rtm_alu #(.n(n)) u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .imm   (imm_q),
    .res   (alu_res),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  // rdy_q keeps cmd_ready low until the first edge after reset.
  always_comb begin
    state_d   = state_q;
    cmd_ready = rdy_q && (state_q == S_IDLE);
    accept    = cmd_valid && cmd_ready;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      op_q    <= OP_NOP;
      d_q     <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (accept) begin
        op_q  <= op_e'(cmd_op);
        d_q   <= cmd_d;
        sa_q  <= cmd_sa;
        sb_q  <= cmd_sb;
        imm_q <= cmd_imm;
      end
      if (state_q == S_READ) begin
        a_q <= rf_a;
        b_q <= rf_b;
      end
      if (state_q == S_EXEC) begin
        res_q   <= alu_res;
        zero_q  <= alu_zero;
        carry_q <= alu_carry;
      end
    end
  end

  assign rf_sa     = sa_q;
  assign rf_sb     = sb_q;
  assign rf_d      = d_q;
  assign rf_x      = res_q;
  assign rf_ld     = (state_q == S_WRITE) && (op_q != OP_NOP);
  assign res_valid = (state_q == S_WRITE);
  assign res_data  = res_q;
  assign res_zero  = zero_q;
  assign res_carry = carry_q;

endmodule
